pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RISC-V core's fetch stage. It holds the current fetch address, resets to a configurable vector, and advances sequentially under a fetch handshake. It also applies branch, jump, trap and trap-return redirects with fixed priority, and captures the exception PC. It replaces the plain loadable PC register between the next-PC logic and instruction memory.

## Interface
- WIDTH, 32, address width in bits (≥ 8)
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0040_0180, PC value loaded on trap or misaligned redirect
- INC, 4, sequential increment in bytes

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- fetch_ready  in  1  instruction memory accepts current pc this cycle
- stall  in  1  hold pc (pipeline hazard)
- branch_taken  in  1  redirect to branch_target
- branch_target  in  WIDTH  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  WIDTH  jump destination
- trap  in  1  exception/interrupt request
- trap_ret  in  1  return from trap (pc ← epc)
- pc  out  WIDTH  current fetch address
- pc_plus4  out  WIDTH  pc + INC (combinational, modulo 2^WIDTH)
- pc_valid  out  1  pc is a valid fetch request
- epc  out  WIDTH  saved exception PC
- misaligned  out  1  one-cycle pulse: a redirect target had bits [1:0] ≠ 0

## Operation
- States: BOOT, RUN, BUBBLE.
- Reset values:
  - pc = RESET_VECTOR
  - epc = RESET_VECTOR
  - pc_valid = 0
  - misaligned = 0
  - state = BOOT
- Reset is asynchronous and overrides everything, including mid-redirect.
- Redirect priority per cycle, highest first:
  1. trap: pc ← TRAP_VECTOR, epc ← pc, next state BUBBLE.
  2. trap_ret: pc ← epc, next state RUN.
  3. jump: pc ← jump_target.
  4. branch_taken: pc ← branch_target.
  5. Sequential advance: pc ← pc + INC, only when pc_valid & fetch_ready & !stall.
  6. Otherwise pc holds.
- Misaligned target: if the selected jump or branch target has [1:0] ≠ 0, the unit takes the trap path instead.
  - pc ← TRAP_VECTOR, epc ← pc, next state BUBBLE.
  - misaligned = 1 in the following cycle.
- Redirects are accepted regardless of fetch_ready, stall or state.
- stall blocks only the sequential advance.
- Transitions:
  - BOOT → RUN after one cycle, or → BUBBLE if a trap occurs.
  - BUBBLE → RUN after one cycle, or → BUBBLE if another trap occurs.
  - RUN → BUBBLE on trap or misaligned redirect.
- pc_valid = 1 only in RUN.
- Arithmetic is unsigned modulo 2^WIDTH. Incrementing past all-ones wraps to 0 with no flag.
- epc changes only on a trap or misaligned redirect; trap_ret does not modify it.

## Timing
- All state updates occur on the rising clk edge. A redirect asserted in cycle N is visible on pc in cycle N+1.
- Sequential advance: handshake accepted in cycle N → pc + INC in cycle N+1.
- Trap latency:
  - Cycle N+1: pc = TRAP_VECTOR, pc_valid = 0.
  - Cycle N+2: pc_valid = 1.
- After reset deassertion: first cycle pc_valid = 0, second cycle pc_valid = 1.
- pc_plus4 has zero latency from pc.
- Simultaneous trap and trap_ret: trap wins, and epc takes the current pc, not the old epc.
- Simultaneous jump and branch_taken: jump wins; only the winning target is alignment-checked.

## Structure
- Shared package riscv_pkg holds:
  - PC select encoding: PC_SEQ, PC_HOLD, PC_BRANCH, PC_JUMP, PC_TRAP, PC_RET.
  - State encoding: ST_BOOT, ST_RUN, ST_BUBBLE.
  - Default vectors RESET_VECTOR_DEF and TRAP_VECTOR_DEF.
- One combinational sub-module, pc_next_sel: priority logic and alignment check, producing the select code and the misaligned flag.
- The top level holds the pc, epc, state and misaligned registers.

## Test plan
- Reset and boot: assert rst mid-run, then release → pc = 0x0040_0000, pc_valid = 0 for one cycle, then 1.
- Sequential advance with backpressure: fetch_ready = 1 for 3 cycles → pc = 0x0040_000C. Then fetch_ready = 0 or stall = 1 for 2 cycles → pc holds 0x0040_000C.
- Redirect priority:
  - jump = 1 (0x0040_1000) and branch_taken = 1 (0x0040_2000) together → pc = 0x0040_1000 next cycle.
  - branch only → 0x0040_2000.
- Trap and return:
  - At pc = 0x0040_0010, trap = 1 → pc = 0x0040_0180, epc = 0x0040_0010, pc_valid low for one cycle.
  - Later trap_ret = 1 → pc = 0x0040_0010.
- Misaligned: branch to 0x0040_0022 → pc = 0x0040_0180, misaligned pulses for exactly one cycle, epc = prior pc.
- Wrap: WIDTH = 8, RESET_VECTOR = 8'hF8, three advances → pc = 8'h04; trap asserted together with stall and fetch_ready = 0 is still taken.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage encodings: PC select codes, PC unit states and default vectors.
package riscv_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_HOLD,
    PC_BRANCH,
    PC_JUMP,
    PC_TRAP,
    PC_RET
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_BUBBLE
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0040_0180;
  localparam int          INC_DEF          = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-side bundle between next-PC/control logic (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             fetch_ready;
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             trap;
  logic             trap_ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             pc_valid;
  logic [WIDTH-1:0] epc;
  logic             misaligned;

  modport master (
    output fetch_ready, stall, branch_taken, branch_target, jump, jump_target, trap, trap_ret,
    input  pc, pc_plus4, pc_valid, epc, misaligned
  );

  modport slave (
    input  fetch_ready, stall, branch_taken, branch_target, jump, jump_target, trap, trap_ret,
    output pc, pc_plus4, pc_valid, epc, misaligned
  );
endinterface

// File: rtl/pc_next_sel.sv
// Redirect priority and alignment check; a misaligned jump/branch target is folded into the trap path.
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             trap_i,
  input  logic             trap_ret_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             advance_i,
  output pc_sel_e          sel_o,
  output logic             misaligned_o
);

  always_comb begin
    sel_o        = PC_HOLD;
    misaligned_o = 1'b0;
    if (trap_i) begin
      sel_o = PC_TRAP;
    end else if (trap_ret_i) begin
      sel_o = PC_RET;
    end else if (jump_i) begin
      // only the winning target is alignment-checked
      if (jump_target_i[1:0] != 2'b00) begin
        sel_o        = PC_TRAP;
        misaligned_o = 1'b1;
      end else begin
        sel_o = PC_JUMP;
      end
    end else if (branch_taken_i) begin
      if (branch_target_i[1:0] != 2'b00) begin
        sel_o        = PC_TRAP;
        misaligned_o = 1'b1;
      end else begin
        sel_o = PC_BRANCH;
      end
    end else if (advance_i) begin
      sel_o = PC_SEQ;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: reset vector, handshake-gated advance, prioritised redirects, EPC capture.
module pc_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF[WIDTH-1:0],
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF[WIDTH-1:0],
  parameter int               INC          = INC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);

  localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, epc_q;
  pc_state_e        state_q;
  logic             mis_q;
  pc_sel_e          sel;
  logic             mis_d;
  logic             run;

  assign run = (state_q == ST_RUN);

  pc_next_sel #(.WIDTH(WIDTH)) u_sel (
    .trap_i          (bus.trap),
    .trap_ret_i      (bus.trap_ret),
    .jump_i          (bus.jump),
    .jump_target_i   (bus.jump_target),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .advance_i       (run & bus.fetch_ready & ~bus.stall),
    .sel_o           (sel),
    .misaligned_o    (mis_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= RESET_VECTOR;
      mis_q   <= 1'b0;
      state_q <= ST_BOOT;
    end else begin
      mis_q <= mis_d;
      // every state leaves for RUN unless the trap path is taken
      state_q <= (sel == PC_TRAP) ? ST_BUBBLE : ST_RUN;
      case (sel)
        PC_TRAP: begin
          epc_q <= pc_q;
          pc_q  <= TRAP_VECTOR;
        end
        PC_RET:    pc_q <= epc_q;
        PC_JUMP:   pc_q <= bus.jump_target;
        PC_BRANCH: pc_q <= bus.branch_target;
        PC_SEQ:    pc_q <= pc_q + INC_V;
        default:   pc_q <= pc_q;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + INC_V;
  assign bus.pc_valid   = run;
  assign bus.epc        = epc_q;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Drives a 32-bit and an 8-bit pc_unit with identical stimulus; scoreboards both against a behavioural model.
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) ifa ();
  pc_unit_if #(.WIDTH(8))  ifb ();

  pc_unit #(.WIDTH(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .INC(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    longint pc;
    longint epc;
    bit     vld;
    bit     mis;
  } ms_t;

  ms_t qa[$];
  ms_t qb[$];
  ms_t ma, mb;
  int total = 0;
  int bad   = 0;

  // stimulus variables
  bit     s_rst, s_fr, s_st, s_br, s_jp, s_tp, s_tr;
  longint s_bt, s_jt;

  // Spec-level model: trap path (explicit trap or misaligned winning target), else
  // trap_ret, jump, branch, handshake advance, hold. pc_valid tracks "not just trapped / reset".
  function automatic ms_t nxt(ms_t s, int w, longint rv, longint tv);
    longint m = (64'd1 << w) - 1;
    ms_t    n = s;
    longint tgt;
    bit     red;
    if (s_rst) begin
      n.pc = rv; n.epc = rv; n.vld = 0; n.mis = 0;
      return n;
    end
    red = s_jp || s_br;
    tgt = (s_jp ? s_jt : s_bt) & m;
    n.mis = 0;
    if (s_tp || (!s_tr && red && (tgt % 4 != 0))) begin
      n.epc = s.pc; n.pc = tv; n.vld = 0; n.mis = !s_tp;
      return n;
    end
    n.vld = 1;
    if (s_tr)                         n.pc = s.epc;
    else if (red)                     n.pc = tgt;
    else if (s.vld && s_fr && !s_st)  n.pc = (s.pc + 4) & m;
    return n;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: outputs reflect the last posedge; compare against the oldest expectation
  always @(negedge clk) begin
    ms_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a.pc",       longint'(ifa.pc),         e.pc);
      chk("a.pc_plus4", longint'(ifa.pc_plus4),   (e.pc + 4) & 64'hFFFF_FFFF);
      chk("a.epc",      longint'(ifa.epc),        e.epc);
      chk("a.pc_valid", longint'(ifa.pc_valid),   longint'(e.vld));
      chk("a.misalign", longint'(ifa.misaligned), longint'(e.mis));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b.pc",       longint'(ifb.pc),         e.pc);
      chk("b.pc_plus4", longint'(ifb.pc_plus4),   (e.pc + 4) & 64'hFF);
      chk("b.epc",      longint'(ifb.epc),        e.epc);
      chk("b.pc_valid", longint'(ifb.pc_valid),   longint'(e.vld));
      chk("b.misalign", longint'(ifb.misaligned), longint'(e.mis));
    end
  end

  task automatic step(input bit r, input bit fr, input bit st, input bit br, input longint bt,
                      input bit jp, input longint jt, input bit tp, input bit tr);
    @(negedge clk);
    #1;
    s_rst = r; s_fr = fr; s_st = st; s_br = br; s_bt = bt; s_jp = jp; s_jt = jt; s_tp = tp; s_tr = tr;
    rst = r;
    ifa.fetch_ready = fr; ifa.stall = st; ifa.branch_taken = br; ifa.branch_target = bt[31:0];
    ifa.jump = jp; ifa.jump_target = jt[31:0]; ifa.trap = tp; ifa.trap_ret = tr;
    ifb.fetch_ready = fr; ifb.stall = st; ifb.branch_taken = br; ifb.branch_target = bt[7:0];
    ifb.jump = jp; ifb.jump_target = jt[7:0]; ifb.trap = tp; ifb.trap_ret = tr;
    if (r) begin
      #1;
      chk("a.async_rst_pc", longint'(ifa.pc), 64'h0040_0000);
      chk("b.async_rst_pc", longint'(ifb.pc), 64'hF8);
    end
    ma = nxt(ma, 32, 64'h0040_0000, 64'h0040_0180);
    mb = nxt(mb, 8,  64'hF8,        64'h80);
    qa.push_back(ma);
    qb.push_back(mb);
  endtask

  function automatic longint rtgt();
    longint t = 64'h0040_0000 | longint'($urandom & 32'h0000_FFFC);
    if ($urandom_range(0, 3) == 0) t = t | longint'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    ifa.fetch_ready = 0; ifa.stall = 0; ifa.branch_taken = 0; ifa.branch_target = '0;
    ifa.jump = 0; ifa.jump_target = '0; ifa.trap = 0; ifa.trap_ret = 0;
    ifb.fetch_ready = 0; ifb.stall = 0; ifb.branch_taken = 0; ifb.branch_target = '0;
    ifb.jump = 0; ifb.jump_target = '0; ifb.trap = 0; ifb.trap_ret = 0;
    ma = '{pc: 0, epc: 0, vld: 0, mis: 0};
    mb = ma;

    //    rst fr st br bt             jp jt             tp tr
    step(1, 0, 0, 0, 0,             0, 0,             0, 0);
    step(1, 0, 0, 0, 0,             0, 0,             0, 0);
    step(0, 1, 0, 0, 0,             0, 0,             0, 0);  // boot cycle: no advance
    repeat (3) step(0, 1, 0, 0, 0,  0, 0,             0, 0);  // -> 0x40000C / 8'h04
    repeat (2) step(0, 0, 0, 0, 0,  0, 0,             0, 0);  // no ready: hold
    repeat (2) step(0, 1, 1, 0, 0,  0, 0,             0, 0);  // stall: hold
    step(0, 1, 0, 1, 64'h0040_2000, 1, 64'h0040_1000, 0, 0);  // jump beats branch
    step(0, 0, 0, 1, 64'h0040_2000, 0, 0,             0, 0);  // branch only
    step(0, 0, 0, 1, 64'h0040_0010, 0, 0,             0, 0);
    step(0, 0, 0, 0, 0,             0, 0,             1, 0);  // trap at 0x400010
    step(0, 1, 0, 0, 0,             0, 0,             0, 0);  // bubble
    step(0, 1, 0, 0, 0,             0, 0,             0, 0);
    step(0, 0, 0, 0, 0,             0, 0,             0, 1);  // return to epc
    step(0, 0, 0, 1, 64'h0040_0022, 0, 0,             0, 0);  // misaligned branch
    step(0, 0, 0, 0, 0,             0, 0,             0, 0);
    step(0, 0, 0, 0, 0,             0, 0,             0, 0);
    step(0, 0, 0, 0, 0,             0, 0,             1, 1);  // trap beats trap_ret
    step(0, 0, 1, 0, 0,             0, 0,             1, 0);  // trap with stall, no ready
    step(0, 1, 0, 1, 64'h0040_0003, 1, 64'h0040_0400, 0, 0);  // only jump target checked
    step(0, 1, 0, 1, 64'h0040_0800, 1, 64'h0040_0401, 0, 0);  // misaligned jump wins
    step(0, 1, 0, 0, 0,             1, 64'h0040_0500, 0, 0);
    step(1, 1, 0, 0, 0,             1, 64'h0040_0600, 1, 0);  // reset mid-redirect
    step(0, 1, 0, 0, 0,             0, 0,             0, 0);
    step(0, 1, 0, 0, 0,             0, 64'h0040_FFFC, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, rtgt(), $urandom_range(0, 7) == 0, rtgt(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain left a=%0d b=%0d exp 0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
